// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
// Holds the FSM state encoding and the parameter sanity checks used by the top.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Operand width must split into a whole number of non-empty digits.
    function automatic bit digit_ok(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract slice: {bout, d} = a_d - b_d - bin.
// The extra top bit of the widened difference is the borrow out of this digit.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] wide;

    assign wide = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, bin};
    assign d    = wide[DIGIT-1:0];
    assign bout = wide[DIGIT];

endmodule

// File: rtl/subtractor_serial.sv
// Digit-serial subtractor: a - b computed DIGIT bits per clock, LSB digit first,
// with the borrow chained through a register and a valid/ready handshake on both sides.
module subtractor_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
        $error("subtractor_serial: WIDTH must be a non-zero multiple of DIGIT");
    end

    sub_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bq_q, bq_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_d, raw;
    logic             sat_q;

    logic [DIGIT-1:0] a_dig, b_dig, d_dig;
    logic             bout;
    logic             accept, last;

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (state_q == CALC) && (cnt_q == LAST);

    // One shared slice, fed by a digit mux over the captured operands.
    assign a_dig = a_q[cnt_q * DIGIT +: DIGIT];
    assign b_dig = b_q[cnt_q * DIGIT +: DIGIT];

    sub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_d (a_dig),
        .b_d (b_dig),
        .bin (bq_q),
        .d   (d_dig),
        .bout(bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC) || (state_q == DONE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        bq_d     = bq_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        raw      = res_q;
        raw[cnt_q * DIGIT +: DIGIT] = d_dig;
        if (accept) begin
            cnt_d = '0;
            bq_d  = 1'b0;
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + 1'b1;
            bq_d  = bout;
            res_d = raw;
            // Published outputs only change on the CALC -> DONE step.
            if (last) begin
                borrow_d = bout;
                ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
                diff_d   = (sat_q && bout) ? '0 : raw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            bq_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bq_q     <= bq_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Operand and partial-result storage carries no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sat_q <= sat_en;
        end
        res_q <= res_d;
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial: 8-bit/4-bit-digit instance plus a 16-bit/1-bit-digit instance.
module tb_subtractor_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       iv8, ir8, sat8, ov8, or8, bo8, of8, busy8;
    logic [7:0] a8, b8, diff8;

    logic        iv16, ir16, sat16, ov16, or16, bo16, of16, busy16;
    logic [15:0] a16, b16, diff16;

    int n_cmp = 0;
    int n_bad = 0;

    subtractor_serial #(.WIDTH(8), .DIGIT(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sat_en(sat8),
        .out_valid(ov8), .out_ready(or8), .diff(diff8), .borrow(bo8),
        .overflow(of8), .busy(busy8)
    );

    subtractor_serial #(.WIDTH(16), .DIGIT(1)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sat_en(sat16),
        .out_valid(ov16), .out_ready(or16), .diff(diff16), .borrow(bo16),
        .overflow(of16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 8-bit transaction with exact latency checks; consumer accepts immediately.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sat,
                        input logic [7:0] ed, input logic eb, input logic eo, input string tag);
        a8 = a; b8 = b; sat8 = sat;
        check({tag, "/in_ready"}, 32'(ir8), 32'd1);
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check({tag, "/busy"}, 32'(busy8), 32'd1);
        check({tag, "/vld_e0"}, 32'(ov8), 32'd0);
        @(posedge clk); #1;
        check({tag, "/vld_e1"}, 32'(ov8), 32'd0);
        @(posedge clk); #1;
        check({tag, "/vld_e2"}, 32'(ov8), 32'd1);
        check({tag, "/diff"}, 32'(diff8), 32'(ed));
        check({tag, "/borrow"}, 32'(bo8), 32'(eb));
        check({tag, "/ovf"}, 32'(of8), 32'(eo));
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check({tag, "/vld_drop"}, 32'(ov8), 32'd0);
        check({tag, "/ready_back"}, 32'(ir8), 32'd1);
    endtask

    // 16-bit transaction checked against an arithmetic reference; out_ready16 stays high.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sat, input string tag);
        int n;
        int sa, sb, sd;
        logic [15:0] ed;
        logic eb, eo;
        a16 = a; b16 = b; sat16 = sat;
        iv16 = 1'b1;
        n = 0;
        while (ir16 !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check({tag, "/ready_timeout"}, 32'(ir16), 32'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 0;
        while (ov16 !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/valid"}, 32'(ov16), 32'd1);
        check({tag, "/latency"}, 32'(n), 32'd16);
        sa = $signed(a);
        sb = $signed(b);
        sd = sa - sb;
        eb = (a < b);
        eo = (sd > 32767) || (sd < -32768);
        ed = (sat && eb) ? 16'h0000 : 16'(a - b);
        check({tag, "/diff"}, 32'(diff16), 32'(ed));
        check({tag, "/borrow"}, 32'(bo16), 32'(eb));
        check({tag, "/ovf"}, 32'(of16), 32'(eo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; sat8 = 1'b0; or8 = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; sat16 = 1'b0; or16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst/in_ready", 32'(ir8), 32'd1);
        check("rst/out_valid", 32'(ov8), 32'd0);
        check("rst/busy", 32'(busy8), 32'd0);
        check("rst/diff", 32'(diff8), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run8(8'd50,  8'd25,  1'b0, 8'd25,  1'b0, 1'b0, "50m25");
        run8(8'd15,  8'd20,  1'b0, 8'd251, 1'b1, 1'b0, "15m20");
        run8(8'd15,  8'd20,  1'b1, 8'd0,   1'b1, 1'b0, "15m20sat");
        run8(8'd128, 8'd1,   1'b0, 8'd127, 1'b0, 1'b1, "128m1");
        run8(8'd200, 8'd150, 1'b0, 8'd50,  1'b0, 1'b0, "200m150");
        run8(8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0, "0m1");

        // Backpressure: result held, new operands refused until after the handoff.
        a8 = 8'd90; b8 = 8'd30; sat8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp/valid", 32'(ov8), 32'd1);
        a8 = 8'd7; b8 = 8'd3; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp/hold_valid", 32'(ov8), 32'd1);
            check("bp/hold_diff", 32'(diff8), 32'd60);
            check("bp/hold_borrow", 32'(bo8), 32'd0);
            check("bp/hold_in_ready", 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("bp/release_valid", 32'(ov8), 32'd0);
        check("bp/not_same_cycle", 32'(ir8), 32'd1);
        check("bp/idle_busy", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("bp/accepted_busy", 32'(busy8), 32'd1);
        check("bp/accepted_ready", 32'(ir8), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp/next_valid", 32'(ov8), 32'd1);
        check("bp/next_diff", 32'(diff8), 32'd4);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;

        // Asynchronous reset after the first digit of a transaction.
        a8 = 8'd77; b8 = 8'd11; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst/out_valid", 32'(ov8), 32'd0);
        check("arst/in_ready", 32'(ir8), 32'd1);
        check("arst/busy", 32'(busy8), 32'd0);
        check("arst/diff", 32'(diff8), 32'd0);
        check("arst/borrow", 32'(bo8), 32'd0);
        check("arst/ovf", 32'(of8), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst/ready_after", 32'(ir8), 32'd1);
        run8(8'd100, 8'd40, 1'b0, 8'd60, 1'b0, 1'b0, "100m40");

        // Wide, bit-serial instance.
        run16(16'h0000, 16'h0001, 1'b0, "w16_0m1");
        run16(16'h8000, 16'h0001, 1'b0, "w16_ovf");
        run16(16'h0003, 16'h1234, 1'b1, "w16_sat");
        for (int i = 0; i < 8; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "w16_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
